countdown_timer_multi: RTL

Parametrised successor to the single-display countdown timer. Provides NUM_CH independent countdown channels, each preset by its own quadrature rotary encoder. Each channel supports start/pause/resume, one-shot or auto-reload mode, a done pulse and a PWM/alarm output. A shared two-digit multiplexed 7-segment display shows the channel picked by disp_sel. Sits directly under the TinyTapeout top wrapper.

---
 rtl/countdown_timer_multi.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/countdown_timer_multi.sv
// Multi-channel countdown timer: NUM_CH encoder-preset channels sharing one tick prescaler,
// one PWM ramp and a two-digit multiplexed 7-segment display.
module countdown_timer_multi #(
  parameter int unsigned NUM_CH    = 3,
  parameter int unsigned SEL_W     = 2,
  parameter int unsigned CNT_W     = 7,
  parameter int unsigned MAX_COUNT = 99,
  parameter int unsigned TICK_DIV  = 1000000,
  parameter int unsigned DISP_DIV  = 10000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] enc_a,
  input  logic [NUM_CH-1:0] enc_b,
  input  logic [NUM_CH-1:0] start,
  input  logic [NUM_CH-1:0] reload_mode,
  input  logic [SEL_W-1:0]  disp_sel,
  output logic [NUM_CH-1:0] pwm_out,
  output logic [NUM_CH-1:0] done_pulse,
  output logic [NUM_CH-1:0] running,
  output logic [6:0]        dis_out,
  output logic              dis_ctrl
);

  localparam int unsigned TickW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned DispW = (DISP_DIV > 1) ? $clog2(DISP_DIV) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StPause, StDone} state_e;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  // Two-stage synchronisers plus one delayed copy for edge detection
  logic [NUM_CH-1:0] a_s1_q, a_s2_q, a_d_q, b_s1_q, b_s2_q, st_s1_q, st_s2_q, st_d_q;
  logic [NUM_CH-1:0] a_rise, sedge;

  logic [TickW-1:0] tick_cnt_q, tick_cnt_d;
  logic             tick;
  logic [CNT_W-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [DispW-1:0] disp_cnt_q, disp_cnt_d;
  logic             disp_wrap;

  state_e           state_q  [NUM_CH];
  state_e           state_d  [NUM_CH];
  logic [CNT_W-1:0] count_q  [NUM_CH];
  logic [CNT_W-1:0] count_d  [NUM_CH];
  logic [CNT_W-1:0] preset_q [NUM_CH];
  logic [CNT_W-1:0] preset_d [NUM_CH];
  logic [CNT_W-1:0] step_val [NUM_CH];
  logic [NUM_CH-1:0] blink_q, blink_d, done_q, done_d;

  logic             dis_ctrl_q, dis_ctrl_d;
  logic [6:0]       dis_out_q, dis_out_d;
  logic [CNT_W-1:0] disp_val;
  logic [3:0]       digit;
  logic             sel_ok;

  assign a_rise = a_s2_q & ~a_d_q;
  assign sedge  = st_s2_q & ~st_d_q;

  assign tick       = (tick_cnt_q == TickW'(TICK_DIV - 1));
  assign tick_cnt_d = tick ? '0 : tick_cnt_q + TickW'(1);
  assign pwm_cnt_d  = (pwm_cnt_q == CNT_W'(MAX_COUNT - 1)) ? '0 : pwm_cnt_q + CNT_W'(1);
  assign disp_wrap  = (disp_cnt_q == DispW'(DISP_DIV - 1));
  assign disp_cnt_d = disp_wrap ? '0 : disp_cnt_q + DispW'(1);

  // Saturating encoder step; B high at the A rising edge means counter-clockwise
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      step_val[i] = count_q[i];
      if (a_rise[i] && !b_s2_q[i] && (count_q[i] < CNT_W'(MAX_COUNT))) begin
        step_val[i] = count_q[i] + CNT_W'(1);
      end else if (a_rise[i] && b_s2_q[i] && (count_q[i] != '0)) begin
        step_val[i] = count_q[i] - CNT_W'(1);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i]  = state_q[i];
      count_d[i]  = count_q[i];
      preset_d[i] = preset_q[i];
      blink_d[i]  = blink_q[i];
      done_d[i]   = 1'b0;
      unique case (state_q[i])
        StIdle: begin
          if (sedge[i]) begin
            if (count_q[i] != '0) state_d[i] = StRun;
          end else if (a_rise[i]) begin
            count_d[i]  = step_val[i];
            preset_d[i] = step_val[i];
          end
        end
        StRun: begin
          if (sedge[i]) begin
            state_d[i] = StPause;
          end else if (tick) begin
            if (count_q[i] <= CNT_W'(1)) begin
              done_d[i] = (count_q[i] == CNT_W'(1));
              if (reload_mode[i]) begin
                count_d[i] = preset_q[i];
              end else begin
                count_d[i] = '0;
                state_d[i] = StDone;
                blink_d[i] = 1'b1;
              end
            end else begin
              count_d[i] = count_q[i] - CNT_W'(1);
            end
          end
        end
        StPause: begin
          if (sedge[i]) begin
            state_d[i] = (count_q[i] == '0) ? StIdle : StRun;
          end else if (a_rise[i]) begin
            count_d[i] = step_val[i];
          end
        end
        StDone: begin
          if (sedge[i]) begin
            state_d[i] = StIdle;
            count_d[i] = preset_q[i];
          end else if (tick) begin
            blink_d[i] = ~blink_q[i];
          end
        end
        default: state_d[i] = StIdle;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      running[i] = (state_q[i] == StRun);
      pwm_out[i] = 1'b0;
      if (state_q[i] == StRun || state_q[i] == StPause) begin
        pwm_out[i] = (pwm_cnt_q < count_q[i]);
      end else if (state_q[i] == StDone) begin
        pwm_out[i] = blink_q[i];
      end
    end
  end
  assign done_pulse = done_q;

  // Segment data is computed for the digit that dis_ctrl will select after this edge
  always_comb begin
    disp_val = '0;
    sel_ok   = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (32'(disp_sel) == i) begin
        disp_val = count_q[i];
        sel_ok   = 1'b1;
      end
    end
    dis_ctrl_d = disp_wrap ? ~dis_ctrl_q : dis_ctrl_q;
    digit      = dis_ctrl_d ? 4'(disp_val / CNT_W'(10)) : 4'(disp_val % CNT_W'(10));
    dis_out_d  = sel_ok ? seg7(digit) : 7'h00;
  end
  assign dis_out  = dis_out_q;
  assign dis_ctrl = dis_ctrl_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      a_s1_q     <= '0;
      a_s2_q     <= '0;
      a_d_q      <= '0;
      b_s1_q     <= '0;
      b_s2_q     <= '0;
      st_s1_q    <= '0;
      st_s2_q    <= '0;
      st_d_q     <= '0;
      tick_cnt_q <= '0;
      pwm_cnt_q  <= '0;
      disp_cnt_q <= '0;
      blink_q    <= '0;
      done_q     <= '0;
      dis_ctrl_q <= 1'b0;
      dis_out_q  <= sel_ok ? 7'h3F : 7'h00;
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i]  <= StIdle;
        count_q[i]  <= '0;
        preset_q[i] <= '0;
      end
    end else begin
      a_s1_q     <= enc_a;
      a_s2_q     <= a_s1_q;
      a_d_q      <= a_s2_q;
      b_s1_q     <= enc_b;
      b_s2_q     <= b_s1_q;
      st_s1_q    <= start;
      st_s2_q    <= st_s1_q;
      st_d_q     <= st_s2_q;
      tick_cnt_q <= tick_cnt_d;
      pwm_cnt_q  <= pwm_cnt_d;
      disp_cnt_q <= disp_cnt_d;
      blink_q    <= blink_d;
      done_q     <= done_d;
      dis_ctrl_q <= dis_ctrl_d;
      dis_out_q  <= dis_out_d;
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i]  <= state_d[i];
        count_q[i]  <= count_d[i];
        preset_q[i] <= preset_d[i];
      end
    end
  end

endmodule
